mul_unit: RTL and testbench

- Iterative shift-add multiplier, directly downstream of the multicycle controller.
- Consumes the MUL/UMULL/SMULL decode (`longFlag`, signedness) plus the two register operands from the datapath.
- Produces a 32- or 64-bit product after a fixed latency and raises `done` so the controller FSM can leave its multiply-wait state and write back `ResultLo`/`ResultHi`.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_unit_if.sv | 29 ++
 rtl/mul_unit.sv | 112 +++++++++++
 tb/tb_mul_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the operand width, the counter width and the FSM state encoding.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_unit_if.sv
// Request/result bundle between the multicycle controller (master) and the multiplier (slave).
interface mul_unit_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) ();

  logic             start;
  logic             longFlag;
  logic             signedMul;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic [1:0]       MulFlags;

  modport master (
    output start, longFlag, signedMul, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, MulFlags
  );

  modport slave (
    input  start, longFlag, signedMul, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, MulFlags
  );

endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier: one partial product per RUN cycle, fixed WIDTH-cycle run.
// Signed mode multiplies magnitudes and negates the 2*WIDTH product on the way into DONE.
module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  mul_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_long;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_res_lo;
  logic [WIDTH-1:0]   r_res_hi;
  logic [1:0]         r_flags;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_prod_lo;
  logic [WIDTH-1:0]   w_prod_hi;
  logic               w_n;
  logic               w_z;

  // signedMul only matters for the long forms; the low word of MUL is sign-agnostic.
  assign w_sgn   = bus.longFlag & bus.signedMul;
  assign w_abs_a = (w_sgn && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
  assign w_abs_b = (w_sgn && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

  // The final RUN cycle's partial product is folded in before the result is captured.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? -w_acc_sum : w_acc_sum;
  assign w_prod_lo = w_prod[WIDTH-1:0];
  assign w_prod_hi = r_long ? w_prod[2*WIDTH-1:WIDTH] : '0;
  assign w_n       = r_long ? w_prod[2*WIDTH-1] : w_prod[WIDTH-1];
  assign w_z       = r_long ? (w_prod == '0) : (w_prod_lo == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_long   <= 1'b0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_neg    <= w_sgn & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
            r_long   <= bus.longFlag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_res_lo <= w_prod_lo;
            r_res_hi <= w_prod_hi;
            r_flags  <= {w_n, w_z};
            r_state  <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.ResultLo = r_res_lo;
  assign bus.ResultHi = r_res_hi;
  assign bus.MulFlags = r_flags;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table plus scoreboard queue,
// with hand-written sequences for back-to-back, mid-RUN start and mid-RUN reset.
module tb_mul_unit;

  logic clk = 1'b0;
  logic reset;

  mul_unit_if #(.WIDTH(32)) bus ();

  mul_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        l;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [1:0]  fl;
    int          t0;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   ops = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and act as the output monitor.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("ResultLo", 64'(bus.ResultLo), 64'(e.lo));
          chk("ResultHi", 64'(bus.ResultHi), 64'(e.hi));
          chk("MulFlags", 64'(bus.MulFlags), 64'(e.fl));
          chk("latency", 64'(cyc - e.t0), 64'(33));
          chk("busy_cycles", 64'(busy_cnt), 64'(32));
        end
        $display("op done: lo=%h hi=%h flags=%b cycle=%0d", bus.ResultLo, bus.ResultHi, bus.MulFlags, cyc);
        busy_cnt = 0;
      end
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic l, input logic s,
                        input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] fl);
    exp_t e;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.longFlag  = l;
    bus.signedMul = s;
    bus.start     = 1'b1;
    e.lo = lo; e.hi = hi; e.fl = fl; e.t0 = cyc;
    sb.push_back(e);
    ops++;
    tick();
    bus.start     = 1'b0;
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.longFlag  = 1'($urandom);
    bus.signedMul = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic l,
                                input logic s, output logic [31:0] lo, output logic [31:0] hi,
                                output logic [1:0] fl);
    logic [63:0] p;
    longint      sa;
    longint      sbv;
    if (l && s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = 64'(sa * sbv);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    lo = p[31:0];
    hi = l ? p[63:32] : 32'h0;
    fl = {l ? p[63] : p[31], l ? (p == 64'h0) : (p[31:0] == 32'h0)};
  endfunction

  initial begin
    logic [31:0] ra, rb, elo, ehi;
    logic        rl, rs;
    logic [1:0]  efl;
    int          d0;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 1'b0, 32'd42,       32'h0,        2'b00};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001, 32'hFFFFFFFE, 2'b10};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 2'b10};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h0,        32'h40000000, 2'b00};
    vecs[4] = '{32'h0,        32'h1234,     1'b0, 1'b0, 32'h0,        32'h0,        2'b01};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0,        2'b10};
    vecs[6] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 32'h0,        32'h0,        2'b01};
    vecs[7] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10};
    vecs[8] = '{32'h0,        32'hFFFFFFFB, 1'b1, 1'b1, 32'h0,        32'h0,        2'b01};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.SrcA = 32'h0; bus.SrcB = 32'h0;
    bus.longFlag = 1'b0; bus.signedMul = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_lo", 64'(bus.ResultLo), 64'(0));
    chk("reset_hi", 64'(bus.ResultHi), 64'(0));
    chk("reset_flags", 64'(bus.MulFlags), 64'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].s, vecs[i].lo, vecs[i].hi, vecs[i].fl);
      drain();
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      rl = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rl, rs, elo, ehi, efl);
      launch(ra, rb, rl, rs, elo, ehi, efl);
      drain();
    end

    // Second start mid-RUN must not restart or queue a multiply.
    launch(32'd100, 32'd3, 1'b0, 1'b0, 32'd300, 32'h0, 2'b00);
    repeat (5) tick();
    bus.SrcA = 32'd9; bus.SrcB = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain();
    repeat (3) tick();

    // Start during the DONE cycle launches the next op with no gap.
    launch(32'd11, 32'd13, 1'b0, 1'b0, 32'd143, 32'h0, 2'b00);
    for (int i = 0; i < 100 && !bus.done; i++) tick();
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL b2b_wait: got done=0 expected done=1 within 100 cycles");
    end
    launch(32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 32'hFFFFFFFA, 32'hFFFFFFFF, 2'b10);
    drain();
    repeat (3) tick();

    // Reset in the middle of RUN aborts with no done pulse.
    launch(32'd5, 32'd5, 1'b0, 1'b0, 32'd25, 32'h0, 2'b00);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    sb.delete();
    ops--;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_lo", 64'(bus.ResultLo), 64'(0));
    chk("abort_hi", 64'(bus.ResultHi), 64'(0));
    chk("abort_flags", 64'(bus.MulFlags), 64'(0));
    reset = 1'b0;
    d0 = done_cnt;
    repeat (40) tick();
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    launch(32'd1234, 32'd1000, 1'b1, 1'b0, 32'd1234000, 32'h0, 2'b00);
    drain();
    repeat (3) tick();

    chk("done_count", 64'(done_cnt), 64'(ops));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
